stream_to_axi_b: RTL
====================

Name: stream_to_axi_b

Overview:
- Receive-side counterpart of the B-channel stream capture path.
- Accepts single-beat response packets from the incoming stream, checks the packet type and framing, and buffers valid responses in a small FIFO.
- Replays buffered responses as AXI write responses on an AXI slave B channel toward the local interconnect.
- Sits between the Ethernet receive demux and the AXI slave port of the bridge.

Parameters:
- DATA_WIDTH, 128, stream data width; must be >= ID_WIDTH+2+USER_WIDTH+8 (elaboration error otherwise).
- ID_WIDTH, 32, AXI BID width.
- USER_WIDTH, 64, AXI BUSER width.
- FIFO_DEPTH, 4, response FIFO entries; power of two, >= 2.
- TYPE_B, 8'h02, packet type code for B responses.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- resetn  input  1  synchronous reset, active low, sampled on the rising edge of clk.
- in_valid  input  1  stream beat valid.
- in_ready  output  1  stream beat accept.
- in_last  input  1  last beat of packet.
- in_data  input  DATA_WIDTH  stream beat payload.
- AXIS_bid  output  ID_WIDTH  response ID.
- AXIS_bresp  output  2  response code.
- AXIS_buser  output  USER_WIDTH  response user field.
- AXIS_bvalid  output  1  response valid.
- AXIS_bready  input  1  response accept.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- drop_count  output  16  saturating count of discarded packets.

Behaviour:
- Beat payload layout:
  - bid = in_data[ID_WIDTH-1:0]
  - bresp = in_data[ID_WIDTH+1:ID_WIDTH]
  - buser = in_data[ID_WIDTH+2+USER_WIDTH-1:ID_WIDTH+2]
  - type = in_data[DATA_WIDTH-1:DATA_WIDTH-8]
  - All other bits are ignored.
- A beat is accepted when in_valid && in_ready.
- State machine: IDLE, DROP.
- IDLE:
  - in_ready = !full.
  - Accepted beat with in_last=1 and type==TYPE_B: push {bid,bresp,buser}; stay IDLE.
  - Accepted beat with in_last=1 and type!=TYPE_B: discard; drop_count+1; stay IDLE.
  - Accepted beat with in_last=0 (multi-beat packet, malformed): discard; drop_count+1 (once per packet); go to DROP.
- DROP:
  - in_ready = 1 regardless of FIFO state; every accepted beat is discarded.
  - Accepted beat with in_last=1: return to IDLE.
  - drop_count does not increment in DROP.
- FIFO:
  - Show-ahead; AXIS_bvalid = !empty; AXIS_b* fields = head entry.
  - Push at edge N gives AXIS_bvalid=1 after edge N (visible in cycle N+1) if the FIFO was empty. Latency is 1 cycle.
  - Pop when AXIS_bvalid && AXIS_bready.
  - AXIS_b* stay stable while AXIS_bvalid=1 and AXIS_bready=0.
  - Full: in_ready=0 in IDLE even if a pop happens the same cycle; there is no combinational bready->in_ready path.
  - Simultaneous push and pop when not full and not empty: level unchanged, order preserved.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_level is registered and equals pushes minus pops.
- drop_count saturates at 16'hFFFF.
- Reset (resetn=0 at a rising edge):
  - state=IDLE, FIFO emptied, fifo_level=0, drop_count=0, AXIS_bvalid=0.
  - in_ready is forced to 0 while resetn=0.
  - AXIS_bid/bresp/buser are don't-care while bvalid=0.
  - Reset mid-packet or mid-DROP abandons the packet. Beats after reset are treated as new packets.
- No X on any output after the first reset edge.

Test Plan:
- Single good packet: in_data with type=8'h02, bid=32'h0000_00A5, bresp=2'b00, buser=64'h1234, in_last=1, AXIS_bready=1 -> AXIS_bvalid=1 for exactly one cycle, one cycle after acceptance, carrying bid=A5, bresp=0, buser=1234; drop_count=0.
- Backpressure/full: AXIS_bready=0, push 5 good packets with bid=1..5 -> in_ready=0 after the 4th; fifo_level=4. Then raise bready -> responses leave in order 1,2,3,4; the 5th is accepted once not full and then emitted.
- Wrong type: type=8'h03, in_last=1 -> no AXIS_bvalid; drop_count=1; in_ready remains 1.
- Malformed 3-beat packet (last only on beat 3) followed by a good packet bid=7 -> all 3 beats accepted with no output; drop_count=1; then bid=7 is emitted.
- Simultaneous push/pop at level 2 with bready=1 and a valid beat -> fifo_level stays 2; ordering intact.
- Reset mid-DROP with 3 entries queued -> after reset: bvalid=0, fifo_level=0, drop_count=0, state IDLE; the next good packet is emitted normally.

Source files
------------

// File: rtl/stream_to_axi_b.sv
// stream_to_axi_b: accepts single-beat B-response packets from the receive stream.
// It checks the packet type and framing, buffers good responses in a show-ahead
// FIFO and replays them on an AXI slave B channel.
// Ports:
//   clk, resetn                 clock and synchronous active-low reset
//   in_valid/in_ready/in_last   stream handshake and packet framing
//   in_data                     beat payload
//   AXIS_b*                     AXI B channel toward the interconnect
//   fifo_level                  registered FIFO occupancy
//   drop_count                  saturating count of discarded packets
module stream_to_axi_b #(
    parameter int DATA_WIDTH = 128,
    parameter int ID_WIDTH   = 32,
    parameter int USER_WIDTH = 64,
    parameter int FIFO_DEPTH = 4,
    parameter logic [7:0] TYPE_B = 8'h02
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_last,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic [ID_WIDTH-1:0]           AXIS_bid,
    output logic [1:0]                    AXIS_bresp,
    output logic [USER_WIDTH-1:0]         AXIS_buser,
    output logic                          AXIS_bvalid,
    input  logic                          AXIS_bready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   drop_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = ID_WIDTH + 2 + USER_WIDTH;

    if (DATA_WIDTH < EW + 8) begin : g_bad_width
        $error("DATA_WIDTH too small for ID, BRESP, USER and type fields");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end

    typedef enum logic {IDLE, DROP} state_t;

    state_t state, state_nxt;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [EW-1:0] head;
    logic          full, empty;
    logic          accept, is_b;
    logic          push, pop, drop_inc;
    logic          unused_bits;

    // The entry is simply the low EW payload bits: {buser, bresp, bid}.
    assign is_b        = (in_data[DATA_WIDTH-1 -: 8] == TYPE_B);
    assign full        = (fifo_level == LW'(FIFO_DEPTH));
    assign empty       = (fifo_level == '0);
    assign accept      = in_valid && in_ready;
    assign pop         = AXIS_bvalid && AXIS_bready;
    assign unused_bits = ^in_data;

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept && !in_last) state_nxt = DROP;
            DROP: if (accept && in_last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / control logic. in_ready never looks at AXIS_bready, so a
    // full FIFO blocks input even in a cycle that pops.
    always_comb begin
        in_ready = 1'b0;
        push     = 1'b0;
        drop_inc = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = resetn && !full;
                push     = accept && in_last && is_b;
                drop_inc = accept && !(in_last && is_b);
            end
            DROP: begin
                in_ready = resetn;
            end
            default: ;
        endcase
    end

    // FIFO storage; contents need no reset since outputs are gated by bvalid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data[EW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            drop_count <= '0;
        end else if (drop_inc && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end

    // Gate the head with bvalid so uninitialised storage never reaches the port.
    assign AXIS_bvalid = !empty;
    assign head        = AXIS_bvalid ? mem[rd_ptr] : '0;
    assign AXIS_bid    = head[ID_WIDTH-1:0];
    assign AXIS_bresp  = head[ID_WIDTH+1:ID_WIDTH];
    assign AXIS_buser  = head[EW-1:ID_WIDTH+2];

endmodule
